mult_control: RTL

MULT_CONTROL -- requirements
Module: mult_control

---
 rtl/mult_control_pkg.sv | 21 ++
 rtl/mult_control_if.sv | 25 ++
 rtl/mult_control.sv | 83 ++++++++
 3 files changed

// File: rtl/mult_control_pkg.sv
// Shared types for the shift-add multiplier: controller state encoding and default width.
package mult_pkg;

  localparam int BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DECR  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // Width needed to count 0..bits inclusive.
  function automatic int iter_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/mult_control_if.sv
// Handshake between the multiplier controller (slave) and the datapath/requester side (master).
interface mult_control_if;

  logic start;
  logic Q0;
  logic Zero;
  logic Load_Regs;
  logic Add_Regs;
  logic Shift_Regs;
  logic Decr_P;
  logic busy;
  logic done;
  logic err;

  modport master (
    output start, Q0, Zero,
    input  Load_Regs, Add_Regs, Shift_Regs, Decr_P, busy, done, err
  );

  modport slave (
    input  start, Q0, Zero,
    output Load_Regs, Add_Regs, Shift_Regs, Decr_P, busy, done, err
  );

endinterface

// File: rtl/mult_control.sv
// Moore FSM sequencing a shift-add multiplier datapath, with an inline iteration
// counter that flags runs where the datapath counter never reaches zero.
module mult_control
  import mult_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mult_control_if.slave bus
);

  localparam int             CW       = iter_width(BITS);
  localparam logic [CW-1:0]  ITER_MAX = CW'(BITS);

  state_e        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        // err is cleared on acceptance so it already reads 0 during LOAD.
        if (bus.start) begin
          state_d = S_LOAD;
          iter_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        iter_d  = '0;
        err_d   = 1'b0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.Zero) begin
          state_d = S_DONE;
        end else if (iter_q == ITER_MAX) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (bus.Q0) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_DECR;
      S_DECR: begin
        state_d = S_CHECK;
        if (iter_q != ITER_MAX) begin
          iter_d = iter_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.Load_Regs  = (state_q == S_LOAD);
  assign bus.Add_Regs   = (state_q == S_ADD);
  assign bus.Shift_Regs = (state_q == S_SHIFT);
  assign bus.Decr_P     = (state_q == S_DECR);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = err_q;

endmodule
